// File: rtl/sram_like_arbiter_if.sv
// One SRAM-like port: request/address phase plus in-order data response.
// The side that issues requests uses the master modport. The side that
// accepts them and returns responses uses the slave modport.
interface sram_like_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (output req, wr, size, wstrb, addr, wdata,
                    input  addr_ok, data_ok, rdata);
    modport slave  (input  req, wr, size, wstrb, addr, wdata,
                    output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_like_arbiter.sv
// Two-to-one SRAM-like arbiter: the inst and data requesters share one memory port.
// Arbitration prefers data. A starvation counter forces an inst grant after
// STARVE_LIMIT data grants in a row while inst waits. Once a selection is made,
// it is locked until the memory accepts it. The source of every accepted
// request is queued, so in-order responses can be steered back to the right
// requester.
module sram_like_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 3
) (
    input  logic               i_clk,
    input  logic               i_resetn,
    sram_like_arbiter_if.slave  i_inst,
    sram_like_arbiter_if.slave  i_data,
    sram_like_arbiter_if.master o_mem
);
    localparam int AW = $clog2(MAX_OUTSTANDING);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [CW-1:0] DEPTH      = CW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE = 2'd0, HOLD_INST = 2'd1, HOLD_DATA = 2'd2} state_t;

    state_t                     r_state;
    logic [SW-1:0]              r_starve_cnt;
    logic [MAX_OUTSTANDING-1:0] r_fifo;      // source ID per slot: 0=inst, 1=data
    logic [AW-1:0]              r_wptr;
    logic [AW-1:0]              r_rptr;
    logic [CW-1:0]              r_count;

    logic w_sel_vld;
    logic w_sel_data;
    logic w_sel_req;
    logic w_full;
    logic w_empty;
    logic w_mem_req;
    logic w_accept;
    logic w_resp;
    logic w_head;

    // Selection: locked in HOLD states, arbitrated from live requests in IDLE
    always_comb begin
        w_sel_vld  = 1'b0;
        w_sel_data = 1'b0;
        case (r_state)
            HOLD_INST: begin
                w_sel_vld  = 1'b1;
                w_sel_data = 1'b0;
            end
            HOLD_DATA: begin
                w_sel_vld  = 1'b1;
                w_sel_data = 1'b1;
            end
            default: begin
                if (i_inst.req && i_data.req) begin
                    w_sel_vld  = 1'b1;
                    w_sel_data = (r_starve_cnt != STARVE_MAX);
                end else if (i_data.req) begin
                    w_sel_vld  = 1'b1;
                    w_sel_data = 1'b1;
                end else if (i_inst.req) begin
                    w_sel_vld  = 1'b1;
                    w_sel_data = 1'b0;
                end
            end
        endcase
    end

    assign w_sel_req = w_sel_data ? i_data.req : i_inst.req;
    assign w_full    = (r_count == DEPTH);
    assign w_empty   = (r_count == '0);
    // Reset gates everything visible, so nothing leaks out while resetn is low
    assign w_mem_req = i_resetn & w_sel_vld & w_sel_req & ~w_full;
    assign w_accept  = w_mem_req & o_mem.addr_ok;
    assign w_head    = r_fifo[r_rptr];
    assign w_resp    = i_resetn & o_mem.data_ok & ~w_empty;

    assign o_mem.req   = w_mem_req;
    assign o_mem.wr    = w_sel_data ? i_data.wr    : i_inst.wr;
    assign o_mem.size  = w_sel_data ? i_data.size  : i_inst.size;
    assign o_mem.wstrb = w_sel_data ? i_data.wstrb : i_inst.wstrb;
    assign o_mem.addr  = w_sel_data ? i_data.addr  : i_inst.addr;
    assign o_mem.wdata = w_sel_data ? i_data.wdata : i_inst.wdata;

    assign i_inst.addr_ok = w_accept & ~w_sel_data;
    assign i_data.addr_ok = w_accept &  w_sel_data;
    assign i_inst.data_ok = w_resp & ~w_head;
    assign i_data.data_ok = w_resp &  w_head;
    assign i_inst.rdata   = o_mem.rdata;
    assign i_data.rdata   = o_mem.rdata;

    // FSM: lock an unaccepted selection, release on the accepting cycle
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_sel_vld && !w_accept)
                        r_state <= w_sel_data ? HOLD_DATA : HOLD_INST;
                end
                HOLD_INST, HOLD_DATA: begin
                    if (w_accept)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Starvation counter: counts data grants while inst waits, saturating
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_starve_cnt <= '0;
        end else if (!i_inst.req) begin
            r_starve_cnt <= '0;
        end else if (w_accept && !w_sel_data) begin
            r_starve_cnt <= '0;
        end else if (w_accept && w_sel_data && (r_starve_cnt != STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    // Source-ID order FIFO: push on accept, pop on response
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_fifo  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_fifo[r_wptr] <= w_sel_data;
                r_wptr         <= r_wptr + 1'b1;
            end
            if (w_resp)
                r_rptr <= r_rptr + 1'b1;
            case ({w_accept, w_resp})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: directed scenarios and a long random run.
// All of it is checked every cycle against a transaction-level model.
module tb_sram_like_arbiter;
    localparam int MAXO = 4;
    localparam int LIM  = 3;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    sram_like_arbiter_if inst_bus ();
    sram_like_arbiter_if data_bus ();
    sram_like_arbiter_if mem_bus ();

    sram_like_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(LIM)) dut (
        .i_clk    (clk),
        .i_resetn (resetn),
        .i_inst   (inst_bus),
        .i_data   (data_bus),
        .o_mem    (mem_bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Requester side: a pending flag and held fields per source (0=inst, 1=data)
    bit          pend [2];
    logic        f_wr [2];
    logic [1:0]  f_size [2];
    logic [3:0]  f_wstrb [2];
    logic [31:0] f_addr [2];
    logic [31:0] f_wdata [2];

    // Model: locked source (-1 none), data-win streak, queue of accepted sources
    int m_lock = -1;
    int m_starve = 0;
    int m_q[$];
    int last_grant = -1;

    task automatic raise(input int s);
        pend[s]    = 1'b1;
        f_wr[s]    = 1'($urandom);
        f_size[s]  = 2'($urandom_range(0, 2));
        f_wstrb[s] = 4'($urandom);
        f_addr[s]  = $urandom;
        f_wdata[s] = $urandom;
    endtask

    // One clock: drive at negedge, check at negedge+1, then advance the model
    task automatic cycle(input bit rst_n, input bit want_i, input bit want_d,
                         input bit mao, input bit mdo);
        int sel;
        bit ereq, eacc, eresp;
        int head;
        @(negedge clk);
        resetn = rst_n;
        if (!pend[0] && want_i) raise(0);
        if (!pend[1] && want_d) raise(1);
        inst_bus.req = pend[0]; inst_bus.wr = f_wr[0]; inst_bus.size = f_size[0];
        inst_bus.wstrb = f_wstrb[0]; inst_bus.addr = f_addr[0]; inst_bus.wdata = f_wdata[0];
        data_bus.req = pend[1]; data_bus.wr = f_wr[1]; data_bus.size = f_size[1];
        data_bus.wstrb = f_wstrb[1]; data_bus.addr = f_addr[1]; data_bus.wdata = f_wdata[1];
        mem_bus.addr_ok = mao;
        mem_bus.data_ok = mdo;
        mem_bus.rdata   = $urandom;
        #1;
        if (m_lock >= 0)           sel = m_lock;
        else if (pend[0] && pend[1]) sel = (m_starve == LIM) ? 0 : 1;
        else if (pend[1])          sel = 1;
        else if (pend[0])          sel = 0;
        else                       sel = -1;
        ereq  = rst_n && (sel >= 0) && pend[sel] && (m_q.size() < MAXO);
        eacc  = ereq && mao;
        eresp = rst_n && mdo && (m_q.size() > 0);
        head  = eresp ? m_q[0] : -1;
        chk("mem_req",      32'(mem_bus.req),      32'(ereq));
        chk("inst_addr_ok", 32'(inst_bus.addr_ok), 32'(eacc && sel == 0));
        chk("data_addr_ok", 32'(data_bus.addr_ok), 32'(eacc && sel == 1));
        chk("inst_data_ok", 32'(inst_bus.data_ok), 32'(head == 0));
        chk("data_data_ok", 32'(data_bus.data_ok), 32'(head == 1));
        chk("inst_rdata",   inst_bus.rdata, mem_bus.rdata);
        chk("data_rdata",   data_bus.rdata, mem_bus.rdata);
        if (ereq) begin
            chk("mem_addr",  mem_bus.addr,          f_addr[sel]);
            chk("mem_wdata", mem_bus.wdata,         f_wdata[sel]);
            chk("mem_wr",    32'(mem_bus.wr),       32'(f_wr[sel]));
            chk("mem_size",  32'(mem_bus.size),     32'(f_size[sel]));
            chk("mem_wstrb", 32'(mem_bus.wstrb),    32'(f_wstrb[sel]));
        end
        last_grant = eacc ? sel : -1;
        if (!rst_n) begin
            m_lock = -1;
            m_starve = 0;
            m_q.delete();
        end else begin
            if (eresp) void'(m_q.pop_front());
            if (eacc) m_q.push_back(sel);
            if (!pend[0])                                    m_starve = 0;
            else if (eacc && sel == 0)                       m_starve = 0;
            else if (eacc && sel == 1 && m_starve < LIM)     m_starve++;
            m_lock = eacc ? -1 : sel;
            if (eacc) pend[sel] = 1'b0;
        end
    endtask

    task automatic do_reset();
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] seq;
        int n;
        for (int s = 0; s < 2; s++) raise(s);
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        do_reset();
        do_reset();
        chk("rst_mem_req", 32'(mem_bus.req), 32'd0);

        // Lone data request at 0x1000, accepted immediately, answered 2 cycles later
        raise(1);
        f_addr[1] = 32'h0000_1000;
        cycle(1, 0, 0, 1, 0);
        chk("t1_grant", 32'(last_grant), 32'd1);
        chk("t1_addr", mem_bus.addr, 32'h0000_1000);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1);
        chk("t1_ddok", 32'(data_bus.data_ok), 32'd1);
        chk("t1_idok", 32'(inst_bus.data_ok), 32'd0);

        // Both requesting, memory stalls: data held steady, then inst goes next
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 1, 1, 0, 0);
        chk("t2_hold_addr", mem_bus.addr, f_addr[1]);
        cycle(1, 0, 0, 1, 0);
        chk("t2_grant_d", 32'(last_grant), 32'd1);
        cycle(1, 0, 0, 1, 0);
        chk("t2_grant_i", 32'(last_grant), 32'd0);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);

        // Continuous contention: starvation limit forces every 4th grant to inst
        do_reset();
        seq = '0;
        for (int i = 0; i < 8; i++) begin
            cycle(1, 1, 1, 1, 1);
            seq = {seq[6:0], last_grant == 1};
        end
        chk("t3_order", 32'(seq), 32'h000000EE);

        // Fill the queue with I,D,I,D, see the stall, then drain in order
        do_reset();
        cycle(1, 1, 0, 1, 0);
        cycle(1, 0, 1, 1, 0);
        cycle(1, 1, 0, 1, 0);
        cycle(1, 0, 1, 1, 0);
        cycle(1, 1, 0, 1, 0);
        chk("t4_full_req", 32'(mem_bus.req), 32'd0);
        seq = '0;
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0, 0, 1);
            seq = {seq[5:0], inst_bus.data_ok, data_bus.data_ok};
        end
        chk("t4_resp_order", 32'(seq), 32'h00000099);

        // Push and pop in the same cycle at count=2
        do_reset();
        cycle(1, 1, 0, 1, 0);
        cycle(1, 0, 1, 1, 0);
        cycle(1, 1, 0, 1, 1);
        seq = '0;
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 0, 1);
            seq = {seq[5:0], inst_bus.data_ok, data_bus.data_ok};
        end
        chk("t5_resp_order", 32'(seq), 32'h00000018);

        // Reset with 3 outstanding drops them, a stray response is ignored
        do_reset();
        cycle(1, 1, 0, 1, 0);
        cycle(1, 0, 1, 1, 0);
        cycle(1, 1, 0, 1, 0);
        do_reset();
        cycle(1, 0, 0, 0, 1);
        chk("t6_stray_i", 32'(inst_bus.data_ok), 32'd0);
        chk("t6_stray_d", 32'(data_bus.data_ok), 32'd0);

        // Random traffic with occasional resets
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 200) != 0,
                  ($urandom % 100) < 60, ($urandom % 100) < 60,
                  ($urandom % 100) < 60, ($urandom % 100) < 50);
            if (last_grant >= 0) n++;
        end
        if (n < 100) chk("rand_grants_low", 32'(n), 32'd100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
